// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-locked scheduler sharing one UART byte transmitter
// between NUM_CH requesters, with inter-byte guard gap and completion timeout.
module uart_tx_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 70000,
    parameter int TO_W       = 17
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [8*NUM_CH-1:0]   req_data,
    input  logic [NUM_CH-1:0]     req_last,
    output logic [NUM_CH-1:0]     req_ready,
    input  logic [2:0]            cfg_baud_set,
    output logic [7:0]            tx_data_byte,
    output logic                  tx_send_en,
    output logic [2:0]            tx_baud_set,
    input  logic                  tx_done,
    input  logic                  tx_busy,
    output logic [NUM_CH-1:0]     grant,
    output logic                  busy,
    output logic                  err_timeout
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]   rr, g, arb_idx;
    logic            arb_hit, accept, done_prev, done_rise, to_hit, gap_exp, last_r;
    logic [TO_W-1:0] to_cnt;
    logic [GW-1:0]   gap_cnt;

    // Lowest offset from rr+1 wins: scan offsets high to low, last hit sticks.
    always_comb begin
        logic [CW-1:0] k;
        arb_hit = 1'b0;
        arb_idx = '0;
        k       = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            k = CW'((int'(rr) + i) % NUM_CH);
            if (req_valid[k]) begin
                arb_hit = 1'b1;
                arb_idx = k;
            end
        end
    end

    assign done_rise = tx_done & ~done_prev;
    assign accept    = (state == SEND) & ~tx_busy & ~tx_done & req_valid[g];
    assign to_hit    = (to_cnt == TO_W'(TIMEOUT - 1));
    // Gap lasts max(GAP_CYCLES,1) cycles.
    assign gap_exp   = (gap_cnt <= GW'(1));
    assign busy      = (state != IDLE);

    always_comb begin
        req_ready    = '0;
        req_ready[g] = accept;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_hit) state_nxt = SEND;
            SEND:    if (accept) state_nxt = WAIT;
            WAIT: begin
                if (done_rise)   state_nxt = GAP;
                else if (to_hit) state_nxt = IDLE;
            end
            GAP:     if (gap_exp) state_nxt = last_r ? IDLE : SEND;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rr           <= CW'(NUM_CH - 1);
            g            <= '0;
            grant        <= '0;
            tx_data_byte <= '0;
            tx_send_en   <= 1'b0;
            tx_baud_set  <= '0;
            err_timeout  <= 1'b0;
            last_r       <= 1'b0;
            done_prev    <= 1'b0;
            to_cnt       <= '0;
            gap_cnt      <= '0;
        end else begin
            done_prev   <= tx_done;
            tx_send_en  <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    tx_baud_set <= cfg_baud_set;
                    if (arb_hit) begin
                        g     <= arb_idx;
                        grant <= NUM_CH'(1) << arb_idx;
                    end
                end
                SEND: if (accept) begin
                    tx_data_byte <= req_data[8*g +: 8];
                    last_r       <= req_last[g];
                    tx_send_en   <= 1'b1;
                    to_cnt       <= '0;
                end
                WAIT: begin
                    // A completion edge on the timeout cycle still counts as success.
                    if (done_rise) begin
                        gap_cnt <= GW'(GAP_CYCLES);
                    end else if (to_hit) begin
                        err_timeout <= 1'b1;
                        grant       <= '0;
                        rr          <= g;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                GAP: begin
                    if (gap_exp) begin
                        if (last_r) begin
                            rr    <= g;
                            grant <= '0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: per-channel source queues, transmitter stub, an expected
// byte/owner order, and per-cycle rule checks derived from the block's contract.
module tb_uart_tx_scheduler;
    localparam int NUM_CH = 4;
    localparam int GAP    = 16;
    localparam int TMO    = 400;
    localparam int TOW    = 9;

    logic                 Clk = 1'b0, Rst_n = 1'b0;
    logic [NUM_CH-1:0]    req_valid = '0, req_last = '0, req_ready, grant;
    logic [8*NUM_CH-1:0]  req_data = '0;
    logic [2:0]           cfg_baud_set = '0, tx_baud_set;
    logic [7:0]           tx_data_byte;
    logic                 tx_send_en, busy, err_timeout;
    logic                 tx_done = 1'b0, tx_busy = 1'b0;

    uart_tx_scheduler #(.NUM_CH(NUM_CH), .GAP_CYCLES(GAP), .TIMEOUT(TMO), .TO_W(TOW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .cfg_baud_set(cfg_baud_set),
        .tx_data_byte(tx_data_byte), .tx_send_en(tx_send_en), .tx_baud_set(tx_baud_set),
        .tx_done(tx_done), .tx_busy(tx_busy), .grant(grant), .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic [7:0] data; logic last; } src_t;
    typedef struct { int ch; logic [7:0] data; } exp_t;
    typedef struct { int ch; int gap; } glog_t;

    src_t  src_q[NUM_CH][$];
    exp_t  exp_q[$];
    glog_t glog[$];
    int    send_cycs[$], rise_cycs[$], err_cycs[$];

    int n_cmp = 0, n_bad = 0, cyc = 0, release_cyc = 0, hs_cnt = 0;
    int stub_delay = 20, stub_hold = 3, done_in = 0, hold_left = 0, since = 0;
    bit never_once = 0, nodone = 0, to_track = 0;
    logic [NUM_CH-1:0] hs_prev = '0, grant_prev = '0;
    logic              busy_prev = 1'b0;
    logic [2:0]        baud_prev = '0;
    logic [7:0]        popped = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sources, transmitter stub and per-cycle checks, all on the falling edge.
    always @(negedge Clk) begin
        logic  busy_before, exp_err;
        exp_t  e;
        src_t  t;
        int    n;
        cyc++;
        busy_before = tx_busy;
        if (!Rst_n) begin
            hs_prev = '0; grant_prev = '0; busy_prev = 1'b0; baud_prev = '0;
            to_track = 0; done_in = 0; hold_left = 0; tx_done = 1'b0; tx_busy = 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                if (hs_prev[c] && src_q[c].size() > 0) begin
                    t = src_q[c].pop_front();
                    popped = t.data;
                end
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) tx_done = 1'b0;
            end
            if (done_in > 0) begin
                done_in--;
                if (done_in == 0) begin
                    tx_busy = 1'b0;
                    if (!nodone) begin
                        tx_done = 1'b1;
                        hold_left = stub_hold;
                        rise_cycs.push_back(cyc);
                    end
                end
            end
            if (to_track) since++;
            if (tx_send_en) begin
                tx_busy = 1'b1;
                nodone = never_once;
                never_once = 0;
                done_in = nodone ? 50 : stub_delay;
                if (nodone) begin to_track = 1; since = 0; end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (src_q[c].size() > 0) begin
                t = src_q[c][0];
                req_valid[c] = 1'b1; req_data[8*c +: 8] = t.data; req_last[c] = t.last;
            end else begin
                req_valid[c] = 1'b0; req_data[8*c +: 8] = '0; req_last[c] = 1'b0;
            end
        end
        #1;
        if (Rst_n) begin
            exp_err = to_track && (since == TMO);
            chk("grant_onehot0", $onehot0(grant), 1);
            chk("busy_vs_grant", busy, |grant);
            chk("ready_outside_grant", req_ready & ~grant, 0);
            chk("baud_rule", tx_baud_set, busy_prev ? baud_prev : cfg_baud_set);
            chk("err_timeout", err_timeout, exp_err);
            chk("send_en_vs_accept", tx_send_en, |hs_prev);
            chk("send_while_busy", tx_send_en & busy_before, 0);
            if (tx_send_en) begin
                send_cycs.push_back(cyc);
                chk("send_byte_vs_source", tx_data_byte, popped);
                n = exp_q.size();
                chk("send_expected", n > 0, 1);
                if (n > 0) begin
                    e = exp_q.pop_front();
                    chk("send_order_byte", tx_data_byte, e.data);
                    chk("send_order_owner", grant, 1 << e.ch);
                end
            end
            if (err_timeout) err_cycs.push_back(cyc);
            if (exp_err) to_track = 0;
            if (grant_prev == 0 && grant != 0) glog.push_back('{ch: $clog2(grant), gap: cyc - release_cyc});
            if (grant_prev != 0 && grant == 0) release_cyc = cyc;
            hs_cnt += $countones(req_ready);
            hs_prev = req_ready; grant_prev = grant; busy_prev = busy; baud_prev = tx_baud_set;
        end
    end

    task automatic tick();
        @(negedge Clk);
        #2;
    endtask

    task automatic src_push(input int ch, input logic [7:0] d, input logic l);
        src_q[ch].push_back('{data: d, last: l});
    endtask

    task automatic exp_push(input int ch, input logic [7:0] d);
        exp_q.push_back('{ch: ch, data: d});
    endtask

    function automatic bit quiet();
        bit q = (exp_q.size() == 0) && (grant == '0) && !tx_busy && !tx_done && (done_in == 0);
        for (int c = 0; c < NUM_CH; c++) if (src_q[c].size() != 0) q = 0;
        return q;
    endfunction

    task automatic wait_quiet(input int budget, input string name);
        int n = 0;
        while (!quiet() && n < budget) begin tick(); n++; end
        chk(name, n < budget, 1);
    endtask

    initial begin
        int t0, s0, h0, g0, r0, e0, n;
        int ord3[8] = '{3, 0, 1, 2, 3, 0, 1, 2};
        #3;
        chk("rst_grant", grant, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_send_en", tx_send_en, 0);
        chk("rst_data", tx_data_byte, 0);
        chk("rst_baud", tx_baud_set, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        tick(); tick();
        Rst_n = 1'b1;
        tick();

        // Single byte, 100-cycle transmitter
        stub_delay = 100; stub_hold = 3;
        t0 = cyc; s0 = send_cycs.size(); h0 = hs_cnt;
        src_push(0, 8'hA5, 1'b1); exp_push(0, 8'hA5);
        wait_quiet(400, "t1_budget");
        chk("t1_accepts", hs_cnt - h0, 1);
        chk("t1_sends", send_cycs.size() - s0, 1);
        chk("t1_send_latency", send_cycs[s0] - t0, 3);
        chk("t1_release", release_cyc - send_cycs[s0], 117);
        chk("t1_no_err", err_cycs.size(), 0);

        // 3-byte packet on ch1 while ch2 waits
        stub_delay = 20;
        g0 = glog.size();
        src_push(1, 8'h11, 1'b0); src_push(1, 8'h22, 1'b0); src_push(1, 8'h33, 1'b1);
        src_push(2, 8'h44, 1'b1);
        exp_push(1, 8'h11); exp_push(1, 8'h22); exp_push(1, 8'h33); exp_push(2, 8'h44);
        wait_quiet(600, "t2_budget");
        chk("t2_grants", glog.size() - g0, 2);
        chk("t2_first_owner", glog[g0].ch, 1);
        chk("t2_second_owner", glog[g0+1].ch, 2);
        chk("t2_regrant_gap", glog[g0+1].gap, 1);

        // All channels busy: rotation from ch3 (ch2 owned last)
        g0 = glog.size();
        for (int c = 0; c < NUM_CH; c++) begin
            src_push(c, 8'h30 + 8'(c), 1'b1);
            src_push(c, 8'h38 + 8'(c), 1'b1);
        end
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_CH; k++)
                exp_push((3 + k) % NUM_CH, 8'h30 + 8'(r * 8) + 8'((3 + k) % NUM_CH));
        wait_quiet(1000, "t3_budget");
        chk("t3_grants", glog.size() - g0, 8);
        for (int i = 0; i < 8; i++) chk("t3_order", glog[g0+i].ch, ord3[i]);

        // tx_done held high for 600 cycles
        stub_hold = 600;
        r0 = rise_cycs.size(); s0 = send_cycs.size();
        src_push(0, 8'h5A, 1'b0); src_push(0, 8'h5B, 1'b1);
        exp_push(0, 8'h5A); exp_push(0, 8'h5B);
        wait_quiet(2000, "t4_budget");
        chk("t4_rises", rise_cycs.size() - r0, 2);
        chk("t4_sends", send_cycs.size() - s0, 2);
        chk("t4_resend_after_drop", send_cycs[s0+1] - rise_cycs[r0], 601);
        chk("t4_release", release_cyc - rise_cycs[r0+1], 17);
        stub_hold = 3;

        // Transmitter never completes the ch1 byte
        never_once = 1;
        e0 = err_cycs.size(); s0 = send_cycs.size(); g0 = glog.size();
        src_push(1, 8'h77, 1'b1); src_push(3, 8'h99, 1'b1);
        exp_push(1, 8'h77); exp_push(3, 8'h99);
        wait_quiet(1000, "t5_budget");
        chk("t5_err_count", err_cycs.size() - e0, 1);
        chk("t5_err_delay", err_cycs[e0] - send_cycs[s0], TMO);
        chk("t5_next_owner", glog[g0+1].ch, 3);
        chk("t5_next_gap", glog[g0+1].gap, 1);

        // Baud change mid-packet
        cfg_baud_set = 3'd0;
        tick();
        src_push(0, 8'hD0, 1'b0); src_push(0, 8'hD1, 1'b1);
        exp_push(0, 8'hD0); exp_push(0, 8'hD1);
        n = 0;
        while (grant == '0 && n < 20) begin tick(); n++; end
        chk("t6_granted", n < 20, 1);
        cfg_baud_set = 3'd3;
        repeat (5) tick();
        chk("t6_baud_frozen", tx_baud_set, 0);
        wait_quiet(400, "t6_budget");
        tick();
        chk("t6_baud_idle", tx_baud_set, 3);

        // Reset during WAIT
        s0 = send_cycs.size();
        src_push(2, 8'hE1, 1'b1); exp_push(2, 8'hE1);
        n = 0;
        while (send_cycs.size() == s0 && n < 50) begin tick(); n++; end
        chk("t7_sent", n < 50, 1);
        repeat (10) tick();
        Rst_n = 1'b0;
        #1;
        chk("t7_rst_grant", grant, 0);
        chk("t7_rst_ready", req_ready, 0);
        chk("t7_rst_send_en", tx_send_en, 0);
        chk("t7_rst_data", tx_data_byte, 0);
        chk("t7_rst_baud", tx_baud_set, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_err", err_timeout, 0);
        repeat (3) tick();
        Rst_n = 1'b1;
        tick();
        g0 = glog.size();
        src_push(1, 8'hC3, 1'b1); src_push(0, 8'hC0, 1'b1);
        exp_push(0, 8'hC0); exp_push(1, 8'hC3);
        wait_quiet(400, "t7_budget");
        chk("t7_first_after_reset", glog[g0].ch, 0);
        chk("t7_errs_total", err_cycs.size(), 1);

        chk("all_expected_sent", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1);
    end
endmodule
